// File: rtl/stream_transpose_ctrl.sv
// Job-level sequencer for the 16-lane streaming matrix-transpose core.
// It pops input FIFO words into the core, drains the core pipeline, and writes
// exactly ctx_length result words plus one trailer word holding the job's
// cycle count. Backpressure, flush and a flush timeout are handled here.
module stream_transpose_ctrl #(
  parameter int CORE_LATENCY  = 16,
  parameter int FLUSH_TIMEOUT = 64,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ctx_valid,
  input  logic [CNT_W-1:0] ctx_length,
  input  logic             in_empty,
  output logic             in_re,
  input  logic             out_almost_full,
  output logic             core_start,
  output logic             core_clk_en,
  input  logic             core_start_next_stage,
  output logic             out_we,
  output logic             out_sel_trailer,
  output logic [CNT_W-1:0] total_cycles,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // The flush timeout counter is sized to hold at least one full pipeline
  // drain, even if FLUSH_TIMEOUT is overridden below the core depth.
  localparam int TO_MAX = (FLUSH_TIMEOUT > CORE_LATENCY) ? FLUSH_TIMEOUT : CORE_LATENCY;
  localparam int TO_W   = $clog2(TO_MAX + 1);
  // Value of the counter on the last clk_en cycle allowed in FLUSH.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(FLUSH_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STREAM,
    S_FLUSH,
    S_TRAILER,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] in_cnt;
  logic [CNT_W-1:0] out_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             started;   // first in_re of the job has happened
  logic             data_we;   // core result write (not the trailer)
  logic             count_en;  // total_cycles advances this cycle

  // Handshakes that must react to the FIFOs in the same cycle.
  // NOTE: every output of this block gets a default before the case so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    in_re           = 1'b0;
    core_clk_en     = 1'b0;
    out_sel_trailer = 1'b0;
    unique case (state)
      S_STREAM: begin
        in_re       = !in_empty && !out_almost_full && (in_cnt < len_q);
        // The core only advances with a fresh word while streaming, so a word
        // read as out_almost_full rises is still clocked in one cycle later.
        core_clk_en = core_start;
      end
      S_FLUSH:   core_clk_en     = !out_almost_full;
      S_TRAILER: out_sel_trailer = !out_almost_full;
      default: ;
    endcase
  end

  // Core results beyond the job length are dropped.
  assign data_we  = core_start_next_stage && core_clk_en && (out_cnt < len_q);
  assign out_we   = data_we || out_sel_trailer;
  assign busy     = (state != S_IDLE);
  assign count_en = (state == S_STREAM || state == S_FLUSH || state == S_TRAILER)
                    && (started || in_re) && (total_cycles != '1);

  // Job FSM, counters and registered status outputs.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values; blocking ones would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      len_q        <= '0;
      in_cnt       <= '0;
      out_cnt      <= '0;
      to_cnt       <= '0;
      started      <= 1'b0;
      core_start   <= 1'b0;
      total_cycles <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      // FIFO dout is valid the cycle after the read, which is when the core
      // must see it.
      core_start <= in_re;
      done       <= 1'b0;
      if (in_re) begin
        in_cnt  <= in_cnt + CNT_W'(1);
        started <= 1'b1;
      end
      if (data_we) out_cnt <= out_cnt + CNT_W'(1);
      // The trailer carries the pre-increment value since it is the register.
      if (count_en) total_cycles <= total_cycles + CNT_W'(1);

      unique case (state)
        S_IDLE: begin
          if (ctx_valid) begin
            len_q        <= ctx_length;
            in_cnt       <= '0;
            out_cnt      <= '0;
            to_cnt       <= '0;
            started      <= 1'b0;
            total_cycles <= '0;
            err          <= 1'b0;
            state        <= (ctx_length == '0) ? S_TRAILER : S_STREAM;
          end
        end
        S_STREAM: begin
          // All words issued and the last one already handed to the core.
          if (in_cnt == len_q && !core_start) state <= S_FLUSH;
        end
        S_FLUSH: begin
          if (out_cnt == len_q) begin
            state <= S_TRAILER;
          end else if (core_clk_en) begin
            if (to_cnt == TO_LAST) begin
              err   <= 1'b1;
              state <= S_TRAILER;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end
        end
        S_TRAILER: begin
          if (out_sel_trailer) begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_transpose_ctrl.sv
// Self-checking bench for stream_transpose_ctrl. It models the input FIFO and
// a 16-deep clk_en pipeline carrying word tags, checks the controller's rules
// every cycle, and pins each directed job with hand-computed trailer counts.
module tb_stream_transpose_ctrl;

  localparam int LAT   = 16;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             ctx_valid;
  logic [CNT_W-1:0] ctx_length;
  logic             in_empty;
  logic             in_re;
  logic             out_almost_full;
  logic             core_start;
  logic             core_clk_en;
  logic             core_start_next_stage;
  logic             out_we;
  logic             out_sel_trailer;
  logic [CNT_W-1:0] total_cycles;
  logic             busy;
  logic             done;
  logic             err;

  stream_transpose_ctrl #(
    .CORE_LATENCY (LAT),
    .FLUSH_TIMEOUT(64),
    .CNT_W        (CNT_W)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .ctx_valid            (ctx_valid),
    .ctx_length           (ctx_length),
    .in_empty             (in_empty),
    .in_re                (in_re),
    .out_almost_full      (out_almost_full),
    .core_start           (core_start),
    .core_clk_en          (core_clk_en),
    .core_start_next_stage(core_start_next_stage),
    .out_we               (out_we),
    .out_sel_trailer      (out_sel_trailer),
    .total_cycles         (total_cycles),
    .busy                 (busy),
    .done                 (done),
    .err                  (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // ---------------- environment models ----------------
  int       pushed = 0;        // words placed in the input FIFO (stimulus)
  int       popped;            // words read out of it
  int       dout_tag;          // index of the word on FIFO dout
  logic [LAT-1:0] vld_sr;      // core pipeline valid bits
  int       tag_sr [LAT];      // core pipeline word tags
  logic     kill_out = 1'b0;   // ties core_start_next_stage low

  assign in_empty              = (pushed == popped);
  assign core_start_next_stage = vld_sr[LAT-1] && !kill_out;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      popped   <= 0;
      dout_tag <= 0;
      vld_sr   <= '0;
      for (int i = 0; i < LAT; i++) tag_sr[i] <= 0;
    end else begin
      if (in_re) begin
        popped   <= popped + 1;
        dout_tag <= popped;
      end
      if (core_clk_en) begin
        vld_sr    <= {vld_sr[LAT-2:0], core_start};
        tag_sr[0] <= dout_tag;
        for (int i = 1; i < LAT; i++) tag_sr[i] <= tag_sr[i-1];
      end
    end
  end

  // ---------------- per-cycle scoreboard ----------------
  int cyc = 0;
  int job_len, job_base, job_re, job_wr, job_trl, trl_val;
  int first_re_cyc, last_re_cyc;
  int done_pulses = 0;
  bit job_active = 1'b0, job_started = 1'b0;
  bit prev_in_re = 1'b0, prev_trl = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      prev_in_re = 1'b0;
      prev_trl   = 1'b0;
      job_active = 1'b0;
    end else begin
      cyc++;
      check("core_start_is_delayed_in_re", 64'(core_start), 64'(prev_in_re));
      check("done_follows_trailer", 64'(done), 64'(prev_trl));
      if (!busy) check("idle_quiet", 64'({in_re, core_clk_en, out_we}), 64'(0));
      if (in_re) begin
        check("in_re_gating", 64'({in_empty, out_almost_full, busy}), 64'(3'b001));
        check("in_re_within_len", 64'(job_re < job_len), 64'(1));
        if (!job_started) begin
          job_started  = 1'b1;
          first_re_cyc = cyc;
        end
        last_re_cyc = cyc;
        job_re++;
      end
      if (core_start) check("clk_en_with_start", 64'(core_clk_en), 64'(1));
      if (out_almost_full && core_clk_en) check("clk_en_under_afull", 64'(core_start), 64'(1));
      if (job_active && job_trl == 0)
        check("total_cycles_running", 64'(total_cycles), 64'(job_started ? cyc - first_re_cyc : 0));
      if (out_sel_trailer) check("sel_only_with_we", 64'(out_we), 64'(1));
      if (out_we && !out_sel_trailer) begin
        check("wr_needs_core_valid", 64'({core_start_next_stage, core_clk_en}), 64'(2'b11));
        check("wr_within_len", 64'(job_wr < job_len), 64'(1));
        check("wr_order", 64'(tag_sr[LAT-1]), 64'(job_base + job_wr));
        job_wr++;
      end
      if (out_we && out_sel_trailer) begin
        job_trl++;
        trl_val = int'(total_cycles);
      end
      if (done) begin
        done_pulses++;
        job_active = 1'b0;
      end
      prev_in_re = in_re;
      prev_trl   = out_we && out_sel_trailer;
      if (ctx_valid && !busy) begin
        job_active  = 1'b1;
        job_len     = int'(ctx_length);
        job_base    = popped;
        job_re      = 0;
        job_wr      = 0;
        job_trl     = 0;
        job_started = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_job(input string name, input int len);
    @(posedge clk); #1;
    ctx_valid  = 1'b1;
    ctx_length = CNT_W'(len);
    @(posedge clk); #1;
    ctx_valid  = 1'b0;
    check({name, "_busy_after_accept"}, 64'(busy), 64'(1));
  endtask

  task automatic finish_job(input string name, input int len, input int exp_wr,
                            input int exp_total, input bit exp_err);
    int budget = 400;
    bit got = 1'b0;
    while (!got && budget > 0) begin
      @(negedge clk);
      if (done) got = 1'b1;
      budget--;
    end
    check({name, "_done_seen"}, 64'(got), 64'(1));
    if (got) begin
      check({name, "_data_writes"}, 64'(job_wr), 64'(exp_wr));
      check({name, "_trailer_writes"}, 64'(job_trl), 64'(1));
      check({name, "_trailer_value"}, 64'(trl_val), 64'(exp_total));
      check({name, "_err"}, 64'(err), 64'(exp_err));
      check({name, "_reads"}, 64'(job_re), 64'(len));
      if (len > 0) check({name, "_total_hold"}, 64'(total_cycles), 64'(exp_total + 1));
    end else begin
      reset  = 1'b0;
      pushed = 0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion, required summary before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed tests ----------------
  initial begin
    int b;
    reset           = 1'b0;
    ctx_valid       = 1'b0;
    ctx_length      = '0;
    out_almost_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_in_re", 64'(in_re), 64'(0));
    check("rst_core_start", 64'(core_start), 64'(0));
    check("rst_core_clk_en", 64'(core_clk_en), 64'(0));
    check("rst_out_we", 64'(out_we), 64'(0));
    check("rst_out_sel_trailer", 64'(out_sel_trailer), 64'(0));
    check("rst_total_cycles", 64'(total_cycles), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    reset = 1'b1;

    // 4 preloaded words: reads c0..c0+3, last result at the 20th clk_en,
    // trailer count 4 + 19 = 23.
    pushed += 4;
    start_job("t1", 4);
    finish_job("t1", 4, 4, 23, 1'b0);
    check("t1_reads_consecutive", 64'(last_re_cyc - first_re_cyc), 64'(3));

    // Zero-length job goes straight to the trailer with count 0.
    start_job("t2", 0);
    finish_job("t2", 0, 0, 0, 1'b0);

    // 8 words unstalled: 8 + 19 = 27.
    pushed += 8;
    start_job("t3a", 8);
    finish_job("t3a", 8, 8, 27, 1'b0);

    // Same job with out_almost_full held 10 cycles mid-stream: 37.
    pushed += 8;
    start_job("t3b", 8);
    b = 0;
    while (job_re < 3 && b < 100) begin
      @(negedge clk);
      b++;
    end
    check("t3b_reached_3_reads", 64'(job_re >= 3), 64'(1));
    @(posedge clk); #1;
    out_almost_full = 1'b1;
    repeat (2) @(negedge clk);
    check("t3b_stall_in_re", 64'(in_re), 64'(0));
    check("t3b_stall_clk_en", 64'(core_clk_en), 64'(0));
    repeat (9) @(posedge clk);
    #1 out_almost_full = 1'b0;
    finish_job("t3b", 8, 8, 37, 1'b0);

    // Core never produces: 3 reads, FLUSH from c0+5 for 64 clk_en cycles,
    // trailer at c0+69 with count 69 and err set.
    kill_out = 1'b1;
    pushed += 3;
    start_job("t4", 3);
    finish_job("t4", 3, 0, 69, 1'b1);
    kill_out = 1'b0;

    // Reset in FLUSH of a 16-word job, then a clean 2-word job (2 + 19 = 21).
    pushed += 16;
    start_job("t5a", 16);
    check("t5a_err_cleared", 64'(err), 64'(0));
    b = 0;
    while (job_re < 16 && b < 200) begin
      @(negedge clk);
      b++;
    end
    check("t5a_reached_16_reads", 64'(job_re), 64'(16));
    repeat (6) @(negedge clk);
    #1;
    reset  = 1'b0;
    pushed = 0;
    #1;
    check("t5_busy_drops", 64'(busy), 64'(0));
    check("t5_no_done", 64'(done), 64'(0));
    check("t5_total_restart", 64'(total_cycles), 64'(0));
    check("t5_quiet", 64'({in_re, core_clk_en, out_we}), 64'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    pushed += 2;
    start_job("t5b", 2);
    finish_job("t5b", 2, 2, 21, 1'b0);

    // ctx_valid while busy is ignored; the 4-word job runs as usual.
    pushed += 4;
    start_job("t6", 4);
    repeat (5) @(posedge clk);
    #1;
    ctx_valid  = 1'b1;
    ctx_length = CNT_W'(100);
    @(posedge clk); #1;
    ctx_valid  = 1'b0;
    finish_job("t6", 4, 4, 23, 1'b0);

    repeat (3) @(posedge clk);
    check("done_pulse_total", 64'(done_pulses), 64'(7));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
